control_multiciclo: RTL and testbench

- Multi-cycle main control FSM for the RV32I core.
- Sequences one shared datapath: a single memory for instructions and data, one ALU, the register bank, and the IR/PC/oldPC/ALUOut/MDR registers. It issues per-state strobes and mux selects.
- Memory accesses use a ready handshake with a timeout.
- Illegal opcodes and memory timeouts park the core in a sticky ERROR state.

---
 rtl/control_pkg.sv | 56 +++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/control_multiciclo.sv | 231 +++++++++++++++++++++++
 tb/tb_control_multiciclo.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states, opcodes,
// ALU operation and datapath mux selects.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_ADR = 4'd11,
        S_JALR_J   = 4'd12,
        S_LUI      = 4'd13,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_BRANCH = 3'b001;
    localparam logic [2:0] ALU_RFUNCT = 3'b010;
    localparam logic [2:0] ALU_IFUNCT = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // funct3[2] picks the less-than compare, funct3[0] inverts the sense.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt);
        return f3[2] ? (lt ^ f3[0]) : (zero ^ f3[0]);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter: counts stalled cycles of an access and flags a
// timeout when the stall reaches MEM_TIMEOUT cycles without mem_ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // A ready in the limit cycle completes the access instead of timing out.
    always_comb begin
        timeout = active && !mem_ready && (cnt_q == LIMIT);
        cnt_d   = 8'd0;
        if (active && !mem_ready && !timeout) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle main control FSM for the RV32I core, driving the shared datapath.
// Optional performance counters are built when CTRL_PERF_EN is defined.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | ALUOut <= oldPC+imm, dispatch on opcode
// MEMADR     | ALUOut <= rs1+imm (load/store address)
// MEMRD      | data read at ALUOut
// MEMWB      | rd <= MDR
// MEMWR      | data write at ALUOut
// EXEC_R/I   | ALU op on rs1 with rs2 / imm
// ALUWB      | rd <= ALUOut
// BRANCH     | compare rs1/rs2, PC <= ALUOut if taken
// JAL        | PC <= ALUOut, ALUOut <= oldPC+4
// JALR_ADR   | ALUOut <= rs1+imm
// JALR_J     | as JAL
// LUI        | ALUOut <= 0+imm
// ERROR      | parked until reset
module control_multiciclo
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero_flag,
    input  logic       lt_flag,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       oldpc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] result_src,
    output logic [3:0] state_o,
    output logic       error,
    output logic       instr_done
`ifdef CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t state_q, state_d;
    logic   mem_active, timeout, taken, f3_bad;

    // Out-of-range parameters leave this named scope in the elaborated hierarchy.
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_params
    end

    assign mem_active = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign taken      = branch_taken(funct3, zero_flag, lt_flag);
    assign f3_bad     = (funct3[2:1] == 2'b01);
    assign state_o    = reset ? S_FETCH : state_q;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .active    (mem_active),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        oldpc_write = 1'b0;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALU_ADD;
        result_src  = RES_ALUOUT;
        error       = 1'b0;
        instr_done  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    if (mem_ready) begin
                        ir_write    = 1'b1;
                        oldpc_write = 1'b1;
                        pc_write    = 1'b1;
                        state_d     = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_ERROR;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_RTYPE:          state_d = S_EXEC_R;
                        OP_ITYPE:          state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR_ADR;
                        OP_LUI:            state_d = S_LUI;
                        OP_AUIPC:          state_d = S_ALUWB;
                        default:           state_d = S_ERROR;
                    endcase
                end
                S_MEMADR, S_JALR_ADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    if (state_q == S_JALR_ADR) begin
                        state_d = S_JALR_J;
                    end else begin
                        state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
                    end
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready)    state_d = S_MEMWB;
                    else if (timeout) state_d = S_ERROR;
                end
                S_MEMWB: begin
                    result_src = RES_MDR;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else if (timeout) begin
                        state_d = S_ERROR;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALU_RFUNCT;
                    state_d   = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_IFUNCT;
                    state_d   = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a = SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALU_BRANCH;
                    if (f3_bad) begin
                        state_d = S_ERROR;
                    end else begin
                        pc_write   = taken;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_JAL, S_JALR_J: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                    state_d   = S_ALUWB;
                end
                S_ERROR: begin
                    error = 1'b1;
                end
                default: begin
                    state_d = S_ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_ERROR) cycle_cnt_d   = cycle_cnt_q + CNT_ONE;
        if (instr_done)         instret_cnt_d = instret_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = reset ? '0 : cycle_cnt_q;
    assign instret_cnt = reset ? '0 : instret_cnt_q;
`endif

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: instruction-level sequence model driving random
// and directed instruction streams, compared against the DUT every cycle.
module tb_control_multiciclo;

    localparam int TMO = 16;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4,
                   ST_MEMWR = 5, ST_EXEC_R = 6, ST_EXEC_I = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                   ST_JAL = 10, ST_JALR_ADR = 11, ST_JALR_J = 12, ST_LUI = 13, ST_ERROR = 15;

    localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5,
                   K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero_flag = 1'b0, lt_flag = 1'b0, mem_ready = 1'b0;
    logic       pc_write, oldpc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_op;
    logic [3:0] state_o;
    logic       error, instr_done;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    control_multiciclo #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .zero_flag(zero_flag), .lt_flag(lt_flag), .mem_ready(mem_ready),
        .pc_write(pc_write), .oldpc_write(oldpc_write), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .state_o(state_o), .error(error), .instr_done(instr_done)
`ifdef CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, oldpc_write, ir_write, iord, mem_read, mem_write, reg_write;
        logic [1:0] a, b;
        logic [2:0] op;
        logic [1:0] rs;
        logic       error, instr_done;
    } exp_t;

    typedef struct packed {
        exp_t        o;
        logic [31:0] pc;
        logic [31:0] pr;
    } rec_t;

    rec_t        exp_q[$];
    logic [13:0] moore [16];
    int          tests = 0, fails = 0, ncmp = 0;
    int          obs_cycles = 0, obs_done = 0, obs_regw = 0, obs_irw = 0, obs_pcw = 0;
    logic [31:0] m_cyc = 0, m_ret = 0;
    logic [6:0]  cur_op = '0;
    logic [2:0]  cur_f3 = '0;
    logic        cur_z = 1'b0, cur_lt = 1'b0;

    function automatic logic [13:0] mk(input logic io, input logic mr, input logic mw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                                       input logic [1:0] rs, input logic er);
        return {io, mr, mw, rw, a, b, op, rs, er};
    endfunction

    // Per-state Moore outputs: iord mem_read mem_write reg_write a b op result_src error.
    task automatic init_tbl();
        for (int i = 0; i < 16; i++) moore[i] = '0;
        moore[ST_FETCH]    = mk(0, 1, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 0);
        moore[ST_DECODE]   = mk(0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 0);
        moore[ST_MEMADR]   = mk(0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 0);
        moore[ST_MEMRD]    = mk(1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        moore[ST_MEMWB]    = mk(0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b01, 0);
        moore[ST_MEMWR]    = mk(1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        moore[ST_EXEC_R]   = mk(0, 0, 0, 0, 2'b10, 2'b00, 3'b010, 2'b00, 0);
        moore[ST_EXEC_I]   = mk(0, 0, 0, 0, 2'b10, 2'b01, 3'b011, 2'b00, 0);
        moore[ST_ALUWB]    = mk(0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        moore[ST_BRANCH]   = mk(0, 0, 0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 0);
        moore[ST_JAL]      = mk(0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00, 0);
        moore[ST_JALR_ADR] = mk(0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 0);
        moore[ST_JALR_J]   = mk(0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b00, 0);
        moore[ST_LUI]      = mk(0, 0, 0, 0, 2'b11, 2'b01, 3'b000, 2'b00, 0);
        moore[ST_ERROR]    = mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] op_of(input int kind);
        case (kind)
            K_LOAD:  return 7'b0000011;
            K_STORE: return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_LUI:   return 7'b0110111;
            K_AUIPC: return 7'b0010111;
            default: return 7'b1111111;
        endcase
    endfunction

    // One clock of stimulus together with the outputs the DUT must show in it.
    task automatic cyc(input int st, input logic rdy, input logic pcw, input logic irw, input logic done);
        rec_t r;
        @(negedge clk);
        reset = 1'b0; mem_ready = rdy; opcode = cur_op; funct3 = cur_f3;
        zero_flag = cur_z; lt_flag = cur_lt;
        r = '0;
        r.o.st = 4'(st);
        {r.o.iord, r.o.mem_read, r.o.mem_write, r.o.reg_write, r.o.a, r.o.b, r.o.op, r.o.rs, r.o.error} = moore[st];
        r.o.pc_write = pcw; r.o.ir_write = irw; r.o.oldpc_write = irw; r.o.instr_done = done;
        r.pc = m_cyc; r.pr = m_ret;
        if (st != ST_ERROR) m_cyc = m_cyc + 1;
        if (done) m_ret = m_ret + 1;
        exp_q.push_back(r);
    endtask

    task automatic rst_cyc();
        rec_t r;
        @(negedge clk);
        reset = 1'b1; mem_ready = rb(); opcode = 7'($urandom); funct3 = 3'($urandom);
        zero_flag = rb(); lt_flag = rb();
        r = '0;
        m_cyc = 0; m_ret = 0;
        exp_q.push_back(r);
    endtask

    task automatic run_instr(input int kind, input logic [2:0] f3, input logic z, input logic lt,
                             input int wf, input int wm);
        logic tk;
        cur_op = op_of(kind); cur_f3 = f3; cur_z = z; cur_lt = lt;
        for (int i = 0; i < wf; i++) cyc(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(ST_FETCH, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(ST_DECODE, rb(), 1'b0, 1'b0, 1'b0);
        case (kind)
            K_LOAD: begin
                cyc(ST_MEMADR, rb(), 0, 0, 0);
                for (int i = 0; i < wm; i++) cyc(ST_MEMRD, 1'b0, 0, 0, 0);
                cyc(ST_MEMRD, 1'b1, 0, 0, 0);
                cyc(ST_MEMWB, rb(), 0, 0, 1);
            end
            K_STORE: begin
                cyc(ST_MEMADR, rb(), 0, 0, 0);
                for (int i = 0; i < wm; i++) cyc(ST_MEMWR, 1'b0, 0, 0, 0);
                cyc(ST_MEMWR, 1'b1, 0, 0, 1);
            end
            K_R:    begin cyc(ST_EXEC_R, rb(), 0, 0, 0); cyc(ST_ALUWB, rb(), 0, 0, 1); end
            K_I:    begin cyc(ST_EXEC_I, rb(), 0, 0, 0); cyc(ST_ALUWB, rb(), 0, 0, 1); end
            K_LUI:  begin cyc(ST_LUI, rb(), 0, 0, 0);    cyc(ST_ALUWB, rb(), 0, 0, 1); end
            K_AUIPC: cyc(ST_ALUWB, rb(), 0, 0, 1);
            K_JAL:  begin cyc(ST_JAL, rb(), 1, 0, 0);    cyc(ST_ALUWB, rb(), 0, 0, 1); end
            K_JALR: begin
                cyc(ST_JALR_ADR, rb(), 0, 0, 0);
                cyc(ST_JALR_J, rb(), 1, 0, 0);
                cyc(ST_ALUWB, rb(), 0, 0, 1);
            end
            K_BR: begin
                case (f3)
                    3'b000:         tk = z;
                    3'b001:         tk = !z;
                    3'b100, 3'b110: tk = lt;
                    3'b101, 3'b111: tk = !lt;
                    default:        tk = 1'b0;
                endcase
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    cyc(ST_BRANCH, rb(), 0, 0, 0);
                    cyc(ST_ERROR, rb(), 0, 0, 0);
                end else begin
                    cyc(ST_BRANCH, rb(), tk, 0, 1);
                end
            end
            default: cyc(ST_ERROR, rb(), 0, 0, 0);
        endcase
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        exp_t g;
        #2;
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            g.st = state_o; g.pc_write = pc_write; g.oldpc_write = oldpc_write;
            g.ir_write = ir_write; g.iord = iord; g.mem_read = mem_read;
            g.mem_write = mem_write; g.reg_write = reg_write; g.a = alu_src_a;
            g.b = alu_src_b; g.op = alu_op; g.rs = result_src; g.error = error;
            g.instr_done = instr_done;
            ncmp++;
            tests++;
            if (g !== r.o) begin
                fails++;
                $display("FAIL cyc%0d outputs: got st=%0d vec=%h, required st=%0d vec=%h",
                         ncmp, g.st, g, r.o.st, r.o);
            end
`ifdef CTRL_PERF_EN
            tests++;
            if (cycle_cnt !== r.pc || instret_cnt !== r.pr) begin
                fails++;
                $display("FAIL cyc%0d perf: got cycle=%0d instret=%0d, required cycle=%0d instret=%0d",
                         ncmp, cycle_cnt, instret_cnt, r.pc, r.pr);
            end
`endif
            obs_cycles++;
            obs_done += int'(instr_done);
            obs_regw += int'(reg_write);
            obs_irw  += int'(ir_write);
            obs_pcw  += int'(pc_write);
        end
    end

    initial begin
        int c0, d0, r0, i0, p0, kind, wf, wm;
        logic [2:0] f3;
        init_tbl();
        rst_cyc();
        rst_cyc();

        // addi x1,x0,5 with no wait states
        settle();
        c0 = obs_cycles; d0 = obs_done; r0 = obs_regw; i0 = obs_irw;
        run_instr(K_I, 3'b000, 1'b0, 1'b0, 0, 0);
        settle();
        chk("addi_cycles", obs_cycles - c0, 4);
        chk("addi_done", obs_done - d0, 1);
        chk("addi_regw", obs_regw - r0, 1);

        // lw with 3 wait states in both FETCH and MEMRD
        c0 = obs_cycles; d0 = obs_done; r0 = obs_regw; i0 = obs_irw;
        run_instr(K_LOAD, 3'b010, 1'b0, 1'b0, 3, 3);
        settle();
        chk("lw_cycles", obs_cycles - c0, 11);
        chk("lw_irw", obs_irw - i0, 1);
        chk("lw_regw", obs_regw - r0, 1);

        p0 = obs_pcw;
        run_instr(K_BR, 3'b000, 1'b1, 1'b0, 0, 0);
        settle();
        chk("beq_z1_pcw", obs_pcw - p0, 2);
        p0 = obs_pcw;
        run_instr(K_BR, 3'b001, 1'b1, 1'b0, 0, 0);
        settle();
        chk("bne_z1_pcw", obs_pcw - p0, 1);
        p0 = obs_pcw;
        run_instr(K_BR, 3'b110, 1'b0, 1'b1, 0, 0);
        settle();
        chk("bltu_lt1_pcw", obs_pcw - p0, 2);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 8);
            f3 = 3'($urandom_range(0, 7));
            if (f3 == 3'b010 || f3 == 3'b011) f3 = f3 ^ 3'b100;
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            run_instr(kind, f3, rb(), rb(), wf, wm);
        end

        // mem_ready exactly at the limit cycle completes the access
        run_instr(K_I, 3'b000, 1'b0, 1'b0, TMO - 1, 0);
        run_instr(K_LOAD, 3'b000, 1'b0, 1'b0, 0, TMO - 1);
        run_instr(K_STORE, 3'b000, 1'b0, 1'b0, TMO - 1, TMO - 1);

        // FETCH timeout, ERROR is sticky, reset clears it
        for (int i = 0; i < TMO; i++) cyc(ST_FETCH, 1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cur_op = op_of($urandom_range(0, 8));
            cyc(ST_ERROR, rb(), 0, 0, 0);
        end
        settle();
        chk("tmo_fetch_state", int'(state_o), 15);
        chk("tmo_fetch_error", int'(error), 1);
        chk("tmo_fetch_mem_read", int'(mem_read), 0);
        rst_cyc();
        settle();
        chk("rst_in_error", int'(error), 0);

        // MEMRD timeout
        cur_op = op_of(K_LOAD);
        cyc(ST_FETCH, 1'b1, 1, 1, 0);
        cyc(ST_DECODE, rb(), 0, 0, 0);
        cyc(ST_MEMADR, rb(), 0, 0, 0);
        for (int i = 0; i < TMO; i++) cyc(ST_MEMRD, 1'b0, 0, 0, 0);
        cyc(ST_ERROR, 1'b1, 0, 0, 0);
        rst_cyc();

        // illegal branch funct3 and illegal opcode
        run_instr(K_BR, 3'b010, 1'b1, 1'b1, 0, 0);
        rst_cyc();
        run_instr(K_ILL, 3'b000, 1'b0, 1'b0, 1, 0);
        cyc(ST_ERROR, 1'b1, 0, 0, 0);
        settle();
        chk("ill_op_state", int'(state_o), 15);
        rst_cyc();

        // reset in the middle of a MEMRD wait; the wait count must not carry over
        settle();
        r0 = obs_regw;
        cur_op = op_of(K_LOAD);
        cyc(ST_FETCH, 1'b1, 1, 1, 0);
        cyc(ST_DECODE, rb(), 0, 0, 0);
        cyc(ST_MEMADR, rb(), 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(ST_MEMRD, 1'b0, 0, 0, 0);
        rst_cyc();
        settle();
        chk("rst_memrd_regw", obs_regw - r0, 0);
        chk("rst_memrd_state", int'(state_o), 0);
        run_instr(K_R, 3'b000, 1'b0, 1'b0, TMO - 1, 0);

`ifdef CTRL_PERF_EN
        rst_cyc();
        run_instr(K_I, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(K_LOAD, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr(K_STORE, 3'b010, 1'b0, 1'b0, 0, 0);
        cyc(ST_FETCH, 1'b0, 0, 0, 0);
        settle();
        chk("perf_cycle_cnt", int'(cycle_cnt), 13);
        chk("perf_instret_cnt", int'(instret_cnt), 3);
        rst_cyc();
`endif

        settle();
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
